// File: rtl/decomp_pkg.sv
// decomp_pkg: shared definitions for the decompression path merge stage.
//   SYM_W / WORD_W / SYMS_PER_WORD : symbol width, merged word width, symbols per word
//   PAD_BYTE_DEFAULT               : default fill byte for unused lanes of a final word
//   seq_state_t                    : merge sequencer states (COLLECT, HOLD)
package decomp_pkg;
   localparam int unsigned SYM_W         = 8;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned SYMS_PER_WORD = 4;

   localparam logic [SYM_W-1:0] PAD_BYTE_DEFAULT = 8'h00;

   typedef logic [SYM_W-1:0]  sym_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      COLLECT,
      HOLD
   } seq_state_t;
endpackage

// File: rtl/merge_sequencer_if.sv
// merge_sequencer_if: symbol input stream and merged word output stream.
//   sym_data/sym_valid/sym_last/sym_ready        : symbol stream (into sequencer)
//   word_data/word_valid/word_last/word_pad/word_ready : word stream (out of sequencer)
//   modport master : the environment (drives symbols, consumes words)
//   modport slave  : the sequencer
interface merge_sequencer_if;
   import decomp_pkg::*;

   sym_t       sym_data;
   logic       sym_valid;
   logic       sym_last;
   logic       sym_ready;
   word_t      word_data;
   logic       word_valid;
   logic       word_last;
   logic [1:0] word_pad;
   logic       word_ready;

   modport master (
      output sym_data, sym_valid, sym_last, word_ready,
      input  sym_ready, word_data, word_valid, word_last, word_pad
   );

   modport slave (
      input  sym_data, sym_valid, sym_last, word_ready,
      output sym_ready, word_data, word_valid, word_last, word_pad
   );
endinterface

// File: rtl/bit_merger.sv
// bit_merger: combinational concatenation of four symbol lanes into one word.
//   lane0..lane3 : symbol lanes, lane0 lands in the most significant byte
//   merged       : {lane0, lane1, lane2, lane3}
module bit_merger
   import decomp_pkg::*;
(
   input  sym_t  lane0,
   input  sym_t  lane1,
   input  sym_t  lane2,
   input  sym_t  lane3,
   output word_t merged
);
   assign merged = {lane0, lane1, lane2, lane3};
endmodule

// File: rtl/merge_sequencer.sv
// merge_sequencer: groups four decoded symbols into a registered 32-bit word.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : symbol input stream and word output stream (merge_sequencer_if)
//   words_out   : words transferred, syms_in : symbols accepted
// Optional build macro MERGE_SEQ_STATS_EN builds the statistics counters;
// without it words_out/syms_in are tied to zero.
module merge_sequencer
   import decomp_pkg::*;
#(
   parameter logic [SYM_W-1:0] PAD_BYTE = PAD_BYTE_DEFAULT,
   parameter int unsigned      CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   merge_sequencer_if.slave bus,
   output logic [CNT_W-1:0] words_out,
   output logic [CNT_W-1:0] syms_in
);
   seq_state_t state, state_nxt;
   logic [1:0] byte_cnt;
   sym_t       b0, b1, b2;
   sym_t       lane0, lane1, lane2, lane3;
   word_t      merged;
   word_t      hold_data;
   logic       hold_last;
   logic [1:0] hold_pad;
   logic       collecting, sym_xfer, word_xfer, out_free, complete;
   logic       load_sym, load_hold, capture_hold;
   logic [1:0] cur_pad;

   // Decoded straight from the state flop so word_ready never reaches sym_ready.
   assign collecting = (state == COLLECT);
   assign sym_xfer   = bus.sym_valid & collecting;
   assign word_xfer  = bus.word_valid & bus.word_ready;
   assign out_free   = ~bus.word_valid | bus.word_ready;
   assign complete   = sym_xfer & ((byte_cnt == 2'd3) | bus.sym_last);
   // Full words complete at byte_cnt==3, giving zero pad from the same formula.
   assign cur_pad    = 2'd3 - byte_cnt;

   // Lane k takes the incoming symbol, lower lanes the stored bytes, higher lanes the fill byte.
   always_comb begin
      lane0 = (byte_cnt == 2'd0) ? bus.sym_data : b0;
      lane1 = (byte_cnt == 2'd1) ? bus.sym_data : ((byte_cnt > 2'd1) ? b1 : PAD_BYTE);
      lane2 = (byte_cnt == 2'd2) ? bus.sym_data : ((byte_cnt == 2'd3) ? b2 : PAD_BYTE);
      lane3 = (byte_cnt == 2'd3) ? bus.sym_data : PAD_BYTE;
   end

   bit_merger u_merger (
      .lane0  (lane0),
      .lane1  (lane1),
      .lane2  (lane2),
      .lane3  (lane3),
      .merged (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (complete && !out_free) state_nxt = HOLD;
         HOLD:    if (out_free)              state_nxt = COLLECT;
      endcase
   end

   always_comb begin
      bus.sym_ready = collecting;
      load_sym      = collecting & complete & out_free;
      capture_hold  = collecting & complete & ~out_free;
      load_hold     = (state == HOLD) & out_free;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         b0       <= '0;
         b1       <= '0;
         b2       <= '0;
      end else if (sym_xfer) begin
         if (complete) begin
            byte_cnt <= '0;
         end else begin
            case (byte_cnt)
               2'd0:    b0 <= bus.sym_data;
               2'd1:    b1 <= bus.sym_data;
               default: b2 <= bus.sym_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_data <= '0;
         hold_last <= 1'b0;
         hold_pad  <= '0;
      end else if (capture_hold) begin
         hold_data <= merged;
         hold_last <= bus.sym_last;
         hold_pad  <= cur_pad;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.word_data  <= '0;
         bus.word_valid <= 1'b0;
         bus.word_last  <= 1'b0;
         bus.word_pad   <= '0;
      end else if (load_sym) begin
         bus.word_data  <= merged;
         bus.word_valid <= 1'b1;
         bus.word_last  <= bus.sym_last;
         bus.word_pad   <= cur_pad;
      end else if (load_hold) begin
         bus.word_data  <= hold_data;
         bus.word_valid <= 1'b1;
         bus.word_last  <= hold_last;
         bus.word_pad   <= hold_pad;
      end else if (word_xfer) begin
         bus.word_valid <= 1'b0;
      end
   end

`ifdef MERGE_SEQ_STATS_EN
   logic [CNT_W-1:0] words_q, syms_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_q <= '0;
         syms_q  <= '0;
      end else begin
         if (word_xfer) words_q <= words_q + CNT_W'(1);
         if (sym_xfer)  syms_q  <= syms_q + CNT_W'(1);
      end
   end

   assign words_out = words_q;
   assign syms_in   = syms_q;
`else
   assign words_out = '0;
   assign syms_in   = '0;
`endif
endmodule

// File: tb/tb_merge_sequencer.sv
// tb_merge_sequencer: directed and random stimulus for merge_sequencer, checked
// against a queue-based reference model. A second instance with PAD_BYTE=8'hEE
// shares the same inputs to cover the fill byte.
module tb_merge_sequencer;
   import decomp_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   merge_sequencer_if bus();
   merge_sequencer_if bus_e();

   assign bus_e.sym_data   = bus.sym_data;
   assign bus_e.sym_valid  = bus.sym_valid;
   assign bus_e.sym_last   = bus.sym_last;
   assign bus_e.word_ready = bus.word_ready;

   logic [31:0] words_out, syms_in, words_out_e, syms_in_e;

   merge_sequencer #(.PAD_BYTE(8'h00), .CNT_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .words_out (words_out),
      .syms_in   (syms_in)
   );

   merge_sequencer #(.PAD_BYTE(8'hEE), .CNT_W(32)) dut_e (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_e.slave),
      .words_out (words_out_e),
      .syms_in   (syms_in_e)
   );

   typedef struct {
      logic [31:0] w0;
      logic [31:0] we;
      logic        last;
      logic [1:0]  pad;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] cur[$];
   int         n_syms = 0;
   int         n_words = 0;
   int         total = 0;
   int         bad = 0;
   bit         rand_ready = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: symbols accumulate in arrival order; four of them, or a last one,
   // form a word with the first symbol in the top byte and fill bytes below.
   function automatic void model_sym(input logic [7:0] s, input logic last);
      exp_t e;
      n_syms++;
      cur.push_back(s);
      if (cur.size() == 4 || last) begin
         e.w0 = '0;
         e.we = '0;
         for (int i = 0; i < 4; i++) begin
            e.w0 = {e.w0[23:0], (i < cur.size()) ? cur[i] : 8'h00};
            e.we = {e.we[23:0], (i < cur.size()) ? cur[i] : 8'hEE};
         end
         e.last = last;
         e.pad  = 2'(4 - cur.size());
         expq.push_back(e);
         cur.delete();
      end
   endfunction

   task automatic cycle();
      logic        sx, wx, stalled, pl;
      logic [31:0] pd;
      logic [1:0]  pp;
      exp_t        e;
      sx = bus.sym_valid && bus.sym_ready;
      wx = bus.word_valid && bus.word_ready;
      if (wx) begin
         check("word_expected", 32'(expq.size() > 0), 32'd1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("word_data", bus.word_data, e.w0);
            check("word_data_padEE", bus_e.word_data, e.we);
            check("word_last", 32'(bus.word_last), 32'(e.last));
            check("word_pad", 32'(bus.word_pad), 32'(e.pad));
            n_words++;
         end
      end
      if (sx) model_sym(bus.sym_data, bus.sym_last);
      stalled = bus.word_valid && !bus.word_ready;
      pd = bus.word_data;
      pl = bus.word_last;
      pp = bus.word_pad;
      @(posedge clk);
      #1;
      if (stalled) begin
         check("stall_valid", 32'(bus.word_valid), 32'd1);
         check("stall_data", bus.word_data, pd);
         check("stall_last", 32'(bus.word_last), 32'(pl));
         check("stall_pad", 32'(bus.word_pad), 32'(pp));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic send(input logic [7:0] s, input logic last);
      int  waited;
      bit  accepted;
      waited = 0;
      bus.sym_data  = s;
      bus.sym_last  = last;
      bus.sym_valid = 1'b1;
      forever begin
         if (rand_ready) bus.word_ready = ($urandom_range(0, 1) == 1);
         accepted = bus.sym_ready;
         cycle();
         if (accepted) break;
         waited++;
         if (waited >= 60) begin
            check("sym_accept_timeout", 32'(bus.sym_ready), 32'd1);
            break;
         end
      end
      bus.sym_valid = 1'b0;
      bus.sym_last  = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_sym_ready"}, 32'(bus.sym_ready), 32'd1);
      check({tag, "_word_valid"}, 32'(bus.word_valid), 32'd0);
      check({tag, "_word_data"}, bus.word_data, 32'd0);
      check({tag, "_word_last"}, 32'(bus.word_last), 32'd0);
      check({tag, "_word_pad"}, 32'(bus.word_pad), 32'd0);
      check({tag, "_syms_in"}, syms_in, 32'd0);
      check({tag, "_words_out"}, words_out, 32'd0);
   endtask

   // Asynchronous assertion away from the clock edge; model state is discarded too.
   task automatic do_reset();
      bus.sym_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      check_idle_outputs("reset");
      cur.delete();
      expq.delete();
      n_syms  = 0;
      n_words = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sq[4];
      bus.sym_data   = '0;
      bus.sym_valid  = 1'b0;
      bus.sym_last   = 1'b0;
      bus.word_ready = 1'b0;

      #3;
      check_idle_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic word, latency one cycle after the fourth symbol.
      bus.word_ready = 1'b1;
      sq = '{8'hF0, 8'hFF, 8'h0F, 8'hF0};
      for (int i = 0; i < 4; i++) send(sq[i], 1'b0);
      check("basic_valid", 32'(bus.word_valid), 32'd1);
      check("basic_data", bus.word_data, 32'hF0FF0FF0);
      check("basic_pad", 32'(bus.word_pad), 32'd0);
      idle(1);
      check("basic_drained", 32'(expq.size()), 32'd0);

      // Streaming, sym_ready never drops.
      for (int i = 1; i <= 8; i++) begin
         check("stream_sym_ready", 32'(bus.sym_ready), 32'd1);
         send(8'(i), 1'b0);
         if (i == 4) check("stream_word0", bus.word_data, 32'h01020304);
         if (i == 8) check("stream_word1", bus.word_data, 32'h05060708);
      end
      idle(1);
      check("stream_drained", 32'(expq.size()), 32'd0);

      // Partial final word.
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      check("partial_data", bus.word_data, 32'hAABB0000);
      check("partial_dataEE", bus_e.word_data, 32'hAABBEEEE);
      check("partial_last", 32'(bus.word_last), 32'd1);
      check("partial_pad", 32'(bus.word_pad), 32'd2);
      idle(1);

      // Last on first symbol and on fourth symbol.
      send(8'h3C, 1'b1);
      check("last_first_pad", 32'(bus.word_pad), 32'd3);
      check("last_first_data", bus.word_data, 32'h3C000000);
      for (int i = 0; i < 4; i++) send(8'(8'h40 + i), i == 3);
      check("last_fourth_pad", 32'(bus.word_pad), 32'd0);
      check("last_fourth_last", 32'(bus.word_last), 32'd1);
      idle(1);

      // Backpressure into HOLD and ordered release.
      sq = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) send(sq[i], 1'b0);
      bus.word_ready = 1'b0;
      sq = '{8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 4; i++) send(sq[i], 1'b0);
      check("bp_hold_ready", 32'(bus.sym_ready), 32'd0);
      idle(3);
      check("bp_still_held", 32'(bus.sym_ready), 32'd0);
      check("bp_first_word", bus.word_data, 32'h11223344);
      bus.word_ready = 1'b1;
      cycle();
      check("bp_second_word", bus.word_data, 32'h55667788);
      check("bp_ready_back", 32'(bus.sym_ready), 32'd1);
      cycle();
      check("bp_drained", 32'(expq.size()), 32'd0);

      // Reset mid-word discards partial bytes.
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      do_reset();
      sq = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
      for (int i = 0; i < 4; i++) send(sq[i], 1'b0);
      check("rst_word_data", bus.word_data, 32'h9ABCDEF0);
      idle(3);
      check("rst_one_word", 32'(n_words), 32'd1);

      // Statistics: 10 symbols, last on the 10th.
      do_reset();
      for (int i = 0; i < 10; i++) send(8'($urandom), i == 9);
      check("stats_final_pad", 32'(bus.word_pad), 32'd2);
      idle(2);
      check("stats_words_model", 32'(n_words), 32'd3);
`ifdef MERGE_SEQ_STATS_EN
      check("stats_syms_in", syms_in, 32'd10);
      check("stats_words_out", words_out, 32'd3);
`else
      check("stats_syms_in_tied", syms_in, 32'd0);
      check("stats_words_out_tied", words_out, 32'd0);
`endif

      // Random traffic with random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            send(8'($urandom), $urandom_range(0, 7) == 0);
         end else begin
            bus.word_ready = ($urandom_range(0, 1) == 1);
            cycle();
         end
      end
      rand_ready = 1'b0;
      bus.word_ready = 1'b1;
      send(8'h5A, 1'b1);
      idle(4);
      check("rand_drained", 32'(expq.size()), 32'd0);
      check("rand_valid_low", 32'(bus.word_valid), 32'd0);
`ifdef MERGE_SEQ_STATS_EN
      check("rand_syms_in", syms_in, 32'(n_syms));
      check("rand_words_out", words_out, 32'(n_words));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/merge_sequencer.md
Name: merge_sequencer

Overview:
Sequences the 32-bit word merge stage of the decompression path.
- Accepts decoded 8-bit symbols from the Huffman decoder on a valid/ready stream.
- Groups every four consecutive symbols, concatenates them through an instance of bit_merger, and presents the result as a registered 32-bit word on a valid/ready output stream.
- Handles end-of-stream padding and downstream backpressure without symbol loss.

Parameters:
PAD_BYTE, 8'h00, fill byte for unused low byte lanes of a final partial word
CNT_W, 32, width of statistics counters (used only with MERGE_SEQ_STATS_EN)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
sym_data  input  8  decoded symbol
sym_valid  input  1  sym_data/sym_last valid
sym_last  input  1  symbol is final symbol of stream
sym_ready  output  1  sequencer accepts symbol this cycle; registered
word_data  output  32  merged word; the first symbol of the word is in [31:24]
word_valid  output  1  word_data valid
word_last  output  1  word contains final symbol of stream
word_pad  output  2  number of PAD_BYTE lanes in word, 0-3
word_ready  input  1  downstream accepts word
words_out  output  CNT_W  words transferred (MERGE_SEQ_STATS_EN only)
syms_in  output  CNT_W  symbols accepted (MERGE_SEQ_STATS_EN only)

Behaviour:
- Reset (async assert, sync release) clears the following:
  - sym_ready=1, state=COLLECT, byte_cnt=0, byte regs b0..b2=0.
  - word_data=0, word_valid=0, word_last=0, word_pad=0, counters=0.
- Transfers and handshake rules:
  - Symbol transfer = sym_valid & sym_ready.
  - Word transfer = word_valid & word_ready.
  - sym_ready is a register output: sym_ready=1 exactly when state==COLLECT. No combinational path from word_ready to sym_ready.
  - word_data/word_valid/word_last/word_pad hold stable while word_valid=1 and word_ready=0.
- Collection: byte_cnt (2 bits) selects the lane. A transfer with byte_cnt<3 and sym_last=0 stores the symbol in b[byte_cnt] and increments byte_cnt.
- Completion occurs on a transfer with byte_cnt==3 or sym_last=1.
  - Merged word = {b0,b1,b2,sym} for byte_cnt==3.
  - For sym_last with byte_cnt=k<3, the symbol occupies lane k, lanes above k are filled with PAD_BYTE, and pad = 3-k.
  - Merge is done by the bit_merger instance fed from lane muxes.
- Output register is free when word_valid==0 or a word transfer occurs this cycle.
  - At completion with the output register free: load word_data/last/pad, set word_valid=1 next cycle, byte_cnt=0, stay in COLLECT. Latency is one cycle from the completing symbol transfer to word_valid.
  - At completion with the output register not free: latch the merged word, last and pad into a hold register and go to HOLD (sym_ready=0 next cycle).
- HOLD: when the output register is free, move the hold contents to the output, clear byte_cnt, and return to COLLECT (sym_ready=1 next cycle).
- Throughput: with word_ready held 1, one word every 4 cycles and sym_ready is never deasserted.
- Boundary conditions:
  - sym_last on the 4th symbol gives word_pad=0, word_last=1.
  - sym_last on the 1st symbol gives pad=3.
  - Words are emitted strictly in order.
  - word_valid is never dropped without a word transfer.
  - Asserting rst_n low mid-word discards partial bytes and any pending or held word.
- Counter wrap: both counters wrap modulo 2^CNT_W.

Optional Feature:
MERGE_SEQ_STATS_EN:
- Defined: syms_in increments on every symbol transfer; words_out increments on every word transfer. Both reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package (decomp_pkg):
  - SYM_W=8, WORD_W=32, SYMS_PER_WORD=4.
  - State enum {COLLECT, HOLD}.
  - Default PAD_BYTE constant.
- Sub-module: the existing bit_merger is instantiated as the combinational concatenation stage. No other sub-module.

Test Plan:
- Basic word: word_ready=1; symbols F0,FF,0F,F0 at cycles 0-3 -> word_data=F0FF0FF0, word_valid=1 at cycle 4, word_last=0, word_pad=0.
- Streaming: 8 back-to-back symbols 01..08 with word_ready=1 -> words 01020304 at cycle 4 and 05060708 at cycle 8; sym_ready stays 1 throughout.
- Partial last: AA, then BB with sym_last=1 -> word AABB0000, word_last=1, word_pad=2. With PAD_BYTE=8'hEE -> AABBEEEE.
- Backpressure: word_ready=0 after word 11223344 appears; feed 55,66,77,88 -> HOLD entered and sym_ready=0. Raise word_ready -> 11223344 then 55667788 delivered in order, then sym_ready returns to 1.
- Reset mid-operation: accept 3 symbols, pulse rst_n low -> all outputs 0. Then feed 9A,BC,DE,F0 -> exactly one word 9ABCDEF0.
- Stats (MERGE_SEQ_STATS_EN defined): 10 symbols with last on the 10th -> syms_in=10, words_out=3, final word_pad=2.
